// File: rtl/rvx_core_load_store_unit.sv
// Load/store unit: issues one data-bus access at a time, builds strobes and write data,
// aligns and extends load data, and stalls stage 1 until the access finishes or times out.
module rvx_core_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_s1,
  input  logic        store_s1,
  input  logic [2:0]  funct3_s1,
  input  logic [31:0] target_address_s1,
  input  logic [31:0] rs2_data_s1,
  input  logic        misaligned_load_s1,
  input  logic        misaligned_store_s1,
  input  logic        flush_s1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  output logic        mem_write_request,
  output logic        mem_read_request,
  input  logic        mem_accept,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid,
  output logic        busy_s1,
  output logic [31:0] load_data_s2,
  output logic        load_data_valid_s2,
  output logic        bus_error_s1
);

  typedef enum logic [1:0] {StIdle, StRequest, StResponse, StComplete} state_e;

  localparam bit         TimeoutEn   = TIMEOUT_CYCLES != 0;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, ldata_q, ldata_d;
  logic [3:0]  strobe_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [7:0]  count_q, count_d;
  logic        capture, cap_en, timeout_hit;
  logic [3:0]  strobe_new;
  logic [31:0] wdata_new, rd_byte_sh, rd_half_sh, ldata_ext;

  assign capture = (load_s1 | store_s1) & ~flush_s1 & ~misaligned_load_s1 &
                   ~misaligned_store_s1;

  always_comb begin
    strobe_new = 4'b0000;
    wdata_new  = rs2_data_s1;
    unique case (funct3_s1[1:0])
      2'b00: begin
        strobe_new = 4'b0001 << target_address_s1[1:0];
        wdata_new  = {4{rs2_data_s1[7:0]}};
      end
      2'b01: begin
        strobe_new = 4'b0011 << {target_address_s1[1], 1'b0};
        wdata_new  = {2{rs2_data_s1[15:0]}};
      end
      default: begin
        strobe_new = 4'b1111;
        wdata_new  = rs2_data_s1;
      end
    endcase
  end

  // Extraction uses the captured address/type, not the live stage-1 inputs.
  assign rd_byte_sh = mem_read_data >> {addr_q[1:0], 3'b000};
  assign rd_half_sh = mem_read_data >> {addr_q[1], 4'b0000};

  always_comb begin
    ldata_ext = mem_read_data;
    unique case (funct3_q[1:0])
      2'b00:   ldata_ext = {{24{~funct3_q[2] & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      2'b01:   ldata_ext = {{16{~funct3_q[2] & rd_half_sh[15]}}, rd_half_sh[15:0]};
      default: ldata_ext = mem_read_data;
    endcase
  end

  assign timeout_hit = TimeoutEn && (count_q == TimeoutLast) &&
                       ((state_q == StRequest) || (state_q == StResponse));

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    ldata_d            = ldata_q;
    cap_en             = 1'b0;
    busy_s1            = 1'b0;
    mem_read_request   = 1'b0;
    mem_write_request  = 1'b0;
    load_data_valid_s2 = 1'b0;
    bus_error_s1       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          cap_en  = 1'b1;
          busy_s1 = 1'b1;
          count_d = 8'd0;
          state_d = StRequest;
        end
      end
      StRequest: begin
        mem_write_request = is_store_q;
        mem_read_request  = ~is_store_q;
        busy_s1           = 1'b1;
        count_d           = count_q + 8'd1;
        if (mem_accept && is_store_q) begin
          busy_s1 = 1'b0;
          state_d = StIdle;
        end else if (timeout_hit) begin
          bus_error_s1 = 1'b1;
          busy_s1      = 1'b0;
          ldata_d      = 32'd0;
          state_d      = StIdle;
        end else if (mem_accept) begin
          state_d = StResponse;
        end
      end
      StResponse: begin
        busy_s1 = 1'b1;
        count_d = count_q + 8'd1;
        // A response arriving on the threshold cycle still completes normally.
        if (mem_read_valid) begin
          ldata_d = ldata_ext;
          state_d = StComplete;
        end else if (timeout_hit) begin
          bus_error_s1 = 1'b1;
          busy_s1      = 1'b0;
          ldata_d      = 32'd0;
          state_d      = StIdle;
        end
      end
      StComplete: begin
        load_data_valid_s2 = 1'b1;
        state_d            = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= 8'd0;
      ldata_q    <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      strobe_q   <= 4'b0000;
      funct3_q   <= 3'b000;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ldata_q <= ldata_d;
      if (cap_en) begin
        addr_q     <= target_address_s1;
        wdata_q    <= wdata_new;
        strobe_q   <= store_s1 ? strobe_new : 4'b0000;
        funct3_q   <= funct3_s1;
        is_store_q <= store_s1;
      end
    end
  end

  assign mem_address      = {addr_q[31:2], 2'b00};
  assign mem_write_data   = wdata_q;
  assign mem_write_strobe = strobe_q;
  assign load_data_s2     = ldata_q;

endmodule

// File: tb/tb_rvx_core_load_store_unit.sv
// Directed bench for the load/store unit; per-cycle compare against a transaction-level model.
module tb_rvx_core_load_store_unit;

  localparam int unsigned T = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_s1 = 1'b0, store_s1 = 1'b0;
  logic [2:0]  funct3_s1 = 3'b000;
  logic [31:0] target_address_s1 = 32'd0, rs2_data_s1 = 32'd0;
  logic        misaligned_load_s1 = 1'b0, misaligned_store_s1 = 1'b0, flush_s1 = 1'b0;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_write_request, mem_read_request;
  logic        mem_accept = 1'b0;
  logic [31:0] mem_read_data = 32'd0;
  logic        mem_read_valid = 1'b0;
  logic        busy_s1;
  logic [31:0] load_data_s2;
  logic        load_data_valid_s2, bus_error_s1;

  rvx_core_load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .load_s1            (load_s1),
    .store_s1           (store_s1),
    .funct3_s1          (funct3_s1),
    .target_address_s1  (target_address_s1),
    .rs2_data_s1        (rs2_data_s1),
    .misaligned_load_s1 (misaligned_load_s1),
    .misaligned_store_s1(misaligned_store_s1),
    .flush_s1           (flush_s1),
    .mem_address        (mem_address),
    .mem_write_data     (mem_write_data),
    .mem_write_strobe   (mem_write_strobe),
    .mem_write_request  (mem_write_request),
    .mem_read_request   (mem_read_request),
    .mem_accept         (mem_accept),
    .mem_read_data      (mem_read_data),
    .mem_read_valid     (mem_read_valid),
    .busy_s1            (busy_s1),
    .load_data_s2       (load_data_s2),
    .load_data_valid_s2 (load_data_valid_s2),
    .bus_error_s1       (bus_error_s1)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  logic        chk_en = 1'b0;
  logic        e_wreq, e_rreq, e_busy, e_valid, e_err;
  logic [31:0] e_addr, e_wdata, e_ldata;
  logic [3:0]  e_strobe;
  int          wreq_cycles;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: size in bytes, naturally aligned lane offset, then plain arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int lane(input logic [31:0] a, input logic [2:0] f3);
    int o;
    o = int'(a % 4);
    return o - (o % nbytes(f3));
  endfunction

  function automatic logic [3:0] model_strobe(input logic [31:0] a, input logic [2:0] f3);
    return 4'(((1 << nbytes(f3)) - 1) << lane(a, f3));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    logic [31:0] w;
    int n;
    n = nbytes(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rs2[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                              input logic [2:0] f3);
    logic [31:0] v, m;
    int n;
    n = nbytes(f3);
    v = rd >> (8 * lane(a, f3));
    if (n < 4) begin
      m = (32'd1 << (8 * n)) - 32'd1;
      v = v & m;
      if (!f3[2] && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("mem_write_request", 32'(mem_write_request), 32'(e_wreq));
      chk("mem_read_request", 32'(mem_read_request), 32'(e_rreq));
      chk("busy_s1", 32'(busy_s1), 32'(e_busy));
      chk("load_data_valid_s2", 32'(load_data_valid_s2), 32'(e_valid));
      chk("bus_error_s1", 32'(bus_error_s1), 32'(e_err));
      chk("load_data_s2", load_data_s2, e_ldata);
      if (e_wreq || e_rreq) begin
        chk("mem_address", mem_address, e_addr);
        chk("mem_write_strobe", 32'(mem_write_strobe), 32'(e_strobe));
      end
      if (e_wreq) chk("mem_write_data", mem_write_data, e_wdata);
      if (mem_write_request) wreq_cycles++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle();
    e_wreq = 1'b0; e_rreq = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_err = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] rs2, input logic [2:0] f3,
                          input int d, input logic flush_in_req);
    store_s1 = 1'b1; funct3_s1 = f3; target_address_s1 = a; rs2_data_s1 = rs2;
    exp_idle(); e_busy = 1'b1;
    e_addr = {a[31:2], 2'b00}; e_wdata = model_wdata(rs2, f3); e_strobe = model_strobe(a, f3);
    for (int i = 0; i <= d; i++) begin
      step();
      flush_s1 = flush_in_req;
      mem_accept = (i == d);
      e_wreq = 1'b1; e_busy = (i != d);
    end
    step();
    mem_accept = 1'b0; store_s1 = 1'b0; flush_s1 = 1'b0;
    exp_idle();
  endtask

  // r < 0 means no response is ever given.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input int d, input int r,
                         input logic [31:0] rd, input logic junk_in_req);
    int cnt;
    logic done;
    done = 1'b0;
    load_s1 = 1'b1; funct3_s1 = f3; target_address_s1 = a; rs2_data_s1 = 32'h5555_AAAA;
    exp_idle(); e_busy = 1'b1;
    e_addr = {a[31:2], 2'b00}; e_strobe = 4'b0000;
    for (int i = 0; i <= d; i++) begin
      step();
      mem_accept = (i == d);
      mem_read_valid = junk_in_req; mem_read_data = junk_in_req ? 32'hBAD0_BAD0 : 32'd0;
      e_rreq = 1'b1; e_busy = 1'b1;
    end
    for (int j = 0; j <= int'(T); j++) begin
      step();
      mem_accept = 1'b0;
      exp_idle();
      cnt = d + 1 + j;
      mem_read_valid = (j == r);
      mem_read_data = (j == r) ? rd : 32'hDEAD_0000;
      if (j == r) begin
        e_busy = 1'b1; done = 1'b1;
        break;
      end else if (cnt == int'(T) - 1) begin
        e_err = 1'b1;
        break;
      end
      e_busy = 1'b1;
    end
    step();
    mem_read_valid = 1'b0;
    exp_idle();
    if (done) begin
      e_valid = 1'b1;
      e_ldata = model_load(rd, a, f3);
      step();
    end else begin
      e_ldata = 32'd0;
    end
    load_s1 = 1'b0;
    exp_idle();
  endtask

  task automatic do_dropped(input logic ld, input logic mis_ld, input logic mis_st,
                            input logic fl);
    load_s1 = ld; store_s1 = ~ld; misaligned_load_s1 = mis_ld; misaligned_store_s1 = mis_st;
    flush_s1 = fl; funct3_s1 = 3'b010; target_address_s1 = 32'h0000_3001;
    exp_idle();
    step();
    load_s1 = 1'b0; store_s1 = 1'b0; misaligned_load_s1 = 1'b0; misaligned_store_s1 = 1'b0;
    flush_s1 = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_idle(); e_ldata = 32'd0; e_addr = 32'd0; e_wdata = 32'd0; e_strobe = 4'b0000;
    wreq_cycles = 0;
    chk_en = 1'b1;

    // Model pins.
    chk("pin_lb", model_load(32'h1234_80FF, 32'h3001, 3'b000), 32'hFFFF_FF80);
    chk("pin_lbu", model_load(32'h1234_80FF, 32'h3001, 3'b100), 32'h0000_0080);
    chk("pin_lhu", model_load(32'h1234_80FF, 32'h3002, 3'b101), 32'h0000_1234);
    chk("pin_sb_strobe", 32'(model_strobe(32'h2003, 3'b000)), 32'h8);
    chk("pin_sb_wdata", model_wdata(32'h0000_00A5, 3'b000), 32'hA5A5_A5A5);
    chk("pin_sh_strobe", 32'(model_strobe(32'h2002, 3'b001)), 32'hC);

    step(); step();
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_write_data", mem_write_data, 32'd0);
    chk("reset_mem_write_strobe", 32'(mem_write_strobe), 32'd0);
    reset_n = 1'b1;
    step();

    wreq_cycles = 0;
    do_store(32'h0000_1004, 32'hDEAD_BEEF, 3'b010, 2, 1'b0);
    chk("sw_wreq_cycles", 32'(wreq_cycles), 32'd3);
    do_store(32'h0000_2003, 32'h0000_00A5, 3'b000, 0, 1'b0);
    do_store(32'h0000_2002, 32'h1234_ABCD, 3'b001, 1, 1'b1);
    do_store(32'h0000_0010, 32'h0BAD_F00D, 3'b010, 3, 1'b0);
    step();

    do_load(32'h0000_3001, 3'b000, 0, 2, 32'h1234_80FF, 1'b0);
    chk("lb_result", load_data_s2, 32'hFFFF_FF80);
    do_load(32'h0000_3001, 3'b100, 1, 0, 32'h1234_80FF, 1'b1);
    do_load(32'h0000_3002, 3'b101, 0, 0, 32'h1234_80FF, 1'b0);
    chk("lhu_result", load_data_s2, 32'h0000_1234);
    do_load(32'h0000_3002, 3'b001, 0, 1, 32'h8001_7F00, 1'b0);
    do_load(32'h0000_3000, 3'b010, 1, 0, 32'hCAFE_F00D, 1'b0);

    do_dropped(1'b1, 1'b1, 1'b0, 1'b0);
    do_dropped(1'b1, 1'b0, 1'b0, 1'b1);
    do_dropped(1'b0, 1'b0, 1'b1, 1'b0);
    do_dropped(1'b0, 1'b0, 1'b0, 1'b1);

    do_load(32'h0000_4000, 3'b010, 0, -1, 32'd0, 1'b0);
    chk("timeout_ldata", load_data_s2, 32'd0);
    step();

    do_load(32'h0000_3003, 3'b100, 0, 0, 32'h7700_0000, 1'b0);
    load_s1 = 1'b1; funct3_s1 = 3'b010; target_address_s1 = 32'h0000_5000;
    exp_idle(); e_busy = 1'b1;
    step();
    mem_accept = 1'b1; load_s1 = 1'b0;
    e_rreq = 1'b1; e_busy = 1'b1; e_addr = 32'h0000_5000; e_strobe = 4'b0000;
    step();
    mem_accept = 1'b0;
    exp_idle(); e_busy = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_rreq", 32'(mem_read_request), 32'd0);
    chk("rst_wreq", 32'(mem_write_request), 32'd0);
    chk("rst_busy", 32'(busy_s1), 32'd0);
    chk("rst_ldata", load_data_s2, 32'd0);
    exp_idle(); e_ldata = 32'd0;
    step();
    reset_n = 1'b1;
    mem_read_valid = 1'b1; mem_read_data = 32'h1111_2222;
    step();
    step();
    mem_read_valid = 1'b0;
    step();

    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvx_core_load_store_unit.md
Name: rvx_core_load_store_unit

Overview:
Executes data-memory accesses for loads and stores whose address, size and alignment the core has already computed in stage 1. It drives a single-outstanding request/accept/response data bus and generates byte strobes and replicated write data. It extracts and sign-/zero-extends load data and stalls stage 1 until each access completes. It also enforces a bus-response timeout.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQUEST+RESPONSE before bus_error_s1 fires; 0 disables the timeout (8-bit counter, max 255).

Ports:
clock  input  1  core clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
load_s1  input  1  stage-1 instruction is a load
store_s1  input  1  stage-1 instruction is a store
funct3_s1  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
target_address_s1  input  32  byte address of the access
rs2_data_s1  input  32  store data
misaligned_load_s1  input  1  access is misaligned, do not issue
misaligned_store_s1  input  1  access is misaligned, do not issue
flush_s1  input  1  stage-1 instruction is being killed
mem_address  output  32  word address {addr[31:2],2'b00}
mem_write_data  output  32  replicated store data
mem_write_strobe  output  4  byte enables; 0000 on reads
mem_write_request  output  1  write request valid
mem_read_request  output  1  read request valid
mem_accept  input  1  bus takes the request this cycle
mem_read_data  input  32  read response word
mem_read_valid  input  1  read response valid
busy_s1  output  1  stall stage 1
load_data_s2  output  32  aligned and extended load result
load_data_valid_s2  output  1  one-cycle pulse with load_data_s2
bus_error_s1  output  1  one-cycle timeout pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE; all mem_* outputs 0; load_data_s2 0; load_data_valid_s2 0; bus_error_s1 0; timeout counter 0.
- Reset asserted mid-transaction drops the request immediately. No completion is reported.
- States: IDLE, REQUEST, RESPONSE, COMPLETE.
- IDLE, capture condition: (load_s1|store_s1) & ~flush_s1 & ~misaligned_load_s1 & ~misaligned_store_s1.
  - On capture: register address, funct3, strobe, write data and load/store type; go to REQUEST.
  - busy_s1=1 combinationally in the capture cycle.
  - Misaligned or flushed ops: no bus activity; busy_s1=0.
- REQUEST:
  - Exactly one of mem_read_request or mem_write_request is 1.
  - All mem_* fields stay stable until mem_accept.
  - Store with mem_accept: posted write; busy_s1=0 this cycle; next state IDLE.
  - Load with mem_accept: next state RESPONSE; busy_s1=1.
  - mem_read_valid is ignored in REQUEST.
- RESPONSE:
  - Requests deasserted; busy_s1=1.
  - On mem_read_valid: register the extracted data; next state COMPLETE.
- COMPLETE (one cycle): load_data_valid_s2=1, busy_s1=0; the s1 op is not recaptured; next state IDLE.
- Strobes:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
- Write data: B {4{rs2[7:0]}}, H {2{rs2[15:0]}}, W rs2.
- Load extraction:
  - Select byte at addr[1:0], or halfword at addr[1].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
  - W passes the word through.
- load_data_s2 holds its value until the next load completes.
- Timeout counter:
  - Clears on entering REQUEST; increments each cycle in REQUEST/RESPONSE.
  - When count==TIMEOUT_CYCLES-1 without completion: bus_error_s1=1 and busy_s1=0 for one cycle; requests drop; load_data_s2 is set to 0 with no valid pulse; next state IDLE.
  - Completion in the same cycle as the timeout threshold wins; no error is raised.
- flush_s1 outside IDLE is ignored: an issued transaction always finishes.
- Only one transaction is outstanding at a time.

Test Plan:
- SW addr 0x1004, rs2 0xDEADBEEF, mem_accept after 2 cycles -> mem_write_request high for 3 cycles, strobe 1111, address 0x1004, data 0xDEADBEEF; busy_s1 low in the accept cycle.
- SB addr 0x2003, rs2 0x000000A5 -> strobe 1000, data 0xA5A5A5A5, address 0x2000.
- LB addr 0x3001, read data 0x1234_80FF, response 3 cycles after accept -> load_data_s2 0xFFFFFF80 with a one-cycle valid pulse; LBU gives 0x00000080; LHU addr 0x3002 gives 0x00001234.
- misaligned_load_s1=1, or flush_s1=1, in IDLE -> no mem request; busy_s1 stays 0.
- TIMEOUT_CYCLES=4, load accepted, no mem_read_valid -> bus_error_s1 pulses on the 4th cycle after entering REQUEST; busy_s1 0 that cycle; next cycle IDLE; no valid pulse.
- reset_n low while in RESPONSE -> mem_read_request/write_request 0 and state IDLE immediately; a later mem_read_valid is ignored.
